// File: rtl/cbfp_pkg.sv
// Shared widths, sample types and helpers for the CBFP block buffer.
package cbfp_pkg;

  localparam int DATA_W = 16;
  localparam int OUT_W  = 9;

  typedef logic signed [DATA_W-1:0] in_samp_t;
  typedef logic signed [OUT_W-1:0]  out_samp_t;

  function automatic int exp_w(input int shift_max);
    return (shift_max < 1) ? 1 : $clog2(shift_max + 1);
  endfunction

  // Copies of the sign bit directly below the MSB of a w-bit value held in x[w-1:0].
  function automatic int rsc(input logic [63:0] x, input int w, input int cap);
    int   n;
    logic run;
    n   = 0;
    run = 1'b1;
    for (int b = 62; b >= 0; b--) begin
      if (b < w - 1 && run) begin
        if (x[b] == x[w-1]) n++;
        else run = 1'b0;
      end
    end
    return (n > cap) ? cap : n;
  endfunction

endpackage

// File: rtl/cbfp_sign_count.sv
// Combinational minimum redundant-sign count over one beat (all I and Q lanes).
module cbfp_sign_count
  import cbfp_pkg::*;
#(
  parameter int NUM_LANES  = 16,
  parameter int DATA_WIDTH = 16,
  parameter int SHIFT_MAX  = 15,
  parameter int EXP_W      = 4
)(
  input  logic [NUM_LANES*DATA_WIDTH-1:0] din_i,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] din_q,
  output logic [EXP_W-1:0]                min_o
);

  int          m_min;
  int          r_i;
  int          r_q;
  logic [63:0] xi;
  logic [63:0] xq;

  always_comb begin
    m_min = SHIFT_MAX;
    r_i   = 0;
    r_q   = 0;
    xi    = '0;
    xq    = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      xi = '0;
      xq = '0;
      xi[DATA_WIDTH-1:0] = din_i[l*DATA_WIDTH +: DATA_WIDTH];
      xq[DATA_WIDTH-1:0] = din_q[l*DATA_WIDTH +: DATA_WIDTH];
      r_i = rsc(xi, DATA_WIDTH, SHIFT_MAX);
      r_q = rsc(xq, DATA_WIDTH, SHIFT_MAX);
      if (r_i < m_min) m_min = r_i;
      if (r_q < m_min) m_min = r_q;
    end
    min_o = EXP_W'(m_min);
  end

endmodule

// File: rtl/cbfp_block_buffer.sv
// CBFP block buffer: holds whole blocks of I/Q beats, tracks each block's common shift and
// emits normalised OUT_WIDTH samples with the block exponent. CBFP_ROUND_EN: round half-up + saturate.
module cbfp_block_buffer
  import cbfp_pkg::*;
#(
  parameter int  NUM_LANES   = 16,
  parameter int  DATA_WIDTH  = 16,
  parameter int  OUT_WIDTH   = 9,
  parameter int  BLOCK_BEATS = 4,
  parameter int  DEPTH       = 16,
  parameter int  SHIFT_MAX   = 15,
  localparam int EXP_W       = exp_w(SHIFT_MAX)
)(
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            clr,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] din_i,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] din_q,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_LANES*OUT_WIDTH-1:0]  dout_i,
  output logic [NUM_LANES*OUT_WIDTH-1:0]  dout_q,
  output logic [EXP_W-1:0]                out_exp,
  output logic                            out_last
);

  localparam int AW   = $clog2(DEPTH);
  localparam int BW   = $clog2(BLOCK_BEATS);
  localparam int NBLK = DEPTH / BLOCK_BEATS;
  localparam int FAW  = (NBLK > 1) ? $clog2(NBLK) : 1;
  localparam int IW   = NUM_LANES * DATA_WIDTH;
  localparam logic [EXP_W-1:0]     EXP_MAX = EXP_W'(SHIFT_MAX);
  localparam logic [OUT_WIDTH-1:0] POS_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};

  logic [IW-1:0]    mem_i_q [DEPTH];
  logic [IW-1:0]    mem_q_q [DEPTH];
  logic [EXP_W-1:0] ef_mem_q [NBLK];

  logic [AW:0]      count_q, count_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [BW-1:0]    wr_beat_q, wr_beat_d, rd_beat_q, rd_beat_d;
  logic [EXP_W-1:0] run_min_q, run_min_d;
  logic [FAW-1:0]   ef_wr_q, ef_wr_d, ef_rd_q, ef_rd_d;
  logic [FAW:0]     ef_cnt_q, ef_cnt_d;

  logic             wr_en, rd_en, wr_last, rd_last, ef_push, ef_pop;
  logic [EXP_W-1:0] beat_min, blk_min, rd_exp;
  logic [IW-1:0]    rd_i, rd_q;

  function automatic logic [FAW-1:0] ef_inc(input logic [FAW-1:0] p);
    return (p == FAW'(NBLK - 1)) ? '0 : p + 1'b1;
  endfunction

  cbfp_sign_count #(
    .NUM_LANES (NUM_LANES),
    .DATA_WIDTH(DATA_WIDTH),
    .SHIFT_MAX (SHIFT_MAX),
    .EXP_W     (EXP_W)
  ) u_sign_count (
    .din_i(din_i),
    .din_q(din_q),
    .min_o(beat_min)
  );

  // Fullness is counted in beats; the exponent FIFO alone decides readability.
  assign in_ready  = count_q < (AW+1)'(DEPTH);
  assign out_valid = ef_cnt_q != '0;
  assign wr_en     = in_valid && in_ready && !clr;
  assign rd_en     = out_valid && out_ready && !clr;
  assign wr_last   = wr_beat_q == BW'(BLOCK_BEATS - 1);
  assign rd_last   = rd_beat_q == BW'(BLOCK_BEATS - 1);
  assign ef_push   = wr_en && wr_last;
  assign ef_pop    = rd_en && rd_last;
  assign blk_min   = (beat_min < run_min_q) ? beat_min : run_min_q;

  always_comb begin
    count_d   = count_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    wr_beat_d = wr_beat_q;
    rd_beat_d = rd_beat_q;
    run_min_d = run_min_q;
    ef_wr_d   = ef_wr_q;
    ef_rd_d   = ef_rd_q;
    ef_cnt_d  = ef_cnt_q;
    if (clr) begin
      count_d   = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      wr_beat_d = '0;
      rd_beat_d = '0;
      run_min_d = EXP_MAX;
      ef_wr_d   = '0;
      ef_rd_d   = '0;
      ef_cnt_d  = '0;
    end else begin
      if (wr_en) begin
        wr_ptr_d  = wr_ptr_q + 1'b1;
        wr_beat_d = wr_beat_q + 1'b1;
        run_min_d = wr_last ? EXP_MAX : blk_min;
      end
      if (rd_en) begin
        rd_ptr_d  = rd_ptr_q + 1'b1;
        rd_beat_d = rd_beat_q + 1'b1;
      end
      if (ef_push) ef_wr_d = ef_inc(ef_wr_q);
      if (ef_pop)  ef_rd_d = ef_inc(ef_rd_q);
      count_d  = count_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
      ef_cnt_d = ef_cnt_q + (FAW+1)'(ef_push) - (FAW+1)'(ef_pop);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      wr_beat_q <= '0;
      rd_beat_q <= '0;
      run_min_q <= EXP_MAX;
      ef_wr_q   <= '0;
      ef_rd_q   <= '0;
      ef_cnt_q  <= '0;
    end else begin
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_beat_q <= wr_beat_d;
      rd_beat_q <= rd_beat_d;
      run_min_q <= run_min_d;
      ef_wr_q   <= ef_wr_d;
      ef_rd_q   <= ef_rd_d;
      ef_cnt_q  <= ef_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_i_q[i] <= '0;
        mem_q_q[i] <= '0;
      end
      for (int b = 0; b < NBLK; b++) ef_mem_q[b] <= '0;
    end else begin
      if (wr_en) begin
        mem_i_q[wr_ptr_q] <= din_i;
        mem_q_q[wr_ptr_q] <= din_q;
      end
      if (ef_push) ef_mem_q[ef_wr_q] <= blk_min;
    end
  end

  assign rd_i     = mem_i_q[rd_ptr_q];
  assign rd_q     = mem_q_q[rd_ptr_q];
  assign rd_exp   = ef_mem_q[ef_rd_q];
  assign out_exp  = out_valid ? rd_exp : '0;
  assign out_last = out_valid && rd_last;

  // The block shift never pushes a significant bit past the MSB, so a plain left shift is exact.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [DATA_WIDTH-1:0] si, sq;
    logic [OUT_WIDTH-1:0]  ti, tq, oi, oq;
    assign si = rd_i[l*DATA_WIDTH +: DATA_WIDTH] << rd_exp;
    assign sq = rd_q[l*DATA_WIDTH +: DATA_WIDTH] << rd_exp;
    assign ti = si[DATA_WIDTH-1 -: OUT_WIDTH];
    assign tq = sq[DATA_WIDTH-1 -: OUT_WIDTH];
`ifdef CBFP_ROUND_EN
    if (OUT_WIDTH < DATA_WIDTH) begin : g_rnd
      assign oi = (si[DATA_WIDTH-OUT_WIDTH-1] && ti != POS_MAX) ? ti + 1'b1 : ti;
      assign oq = (sq[DATA_WIDTH-OUT_WIDTH-1] && tq != POS_MAX) ? tq + 1'b1 : tq;
    end else begin : g_nornd
      assign oi = ti;
      assign oq = tq;
    end
`else
    assign oi = ti;
    assign oq = tq;
`endif
    assign dout_i[l*OUT_WIDTH +: OUT_WIDTH] = out_valid ? oi : '0;
    assign dout_q[l*OUT_WIDTH +: OUT_WIDTH] = out_valid ? oq : '0;
  end

endmodule

// File: tb/tb_cbfp_block_buffer.sv
// Scoreboard bench for cbfp_block_buffer: model pushes expected beats per written block, monitor pops on reads.
module tb_cbfp_block_buffer;
  import cbfp_pkg::*;

  localparam int NL = 16, DW = 16, OW = 9, BB = 4, DEPTH = 16, SM = 15, EW = 4;
  localparam int IW = NL * DW, XW = NL * OW;

  logic          clk = 1'b0, rstn = 1'b0, clr = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [IW-1:0] din_i = '0, din_q = '0;
  logic          in_ready, out_valid, out_last;
  logic [XW-1:0] dout_i, dout_q;
  logic [EW-1:0] out_exp;

  cbfp_block_buffer dut (
    .clk(clk), .rstn(rstn), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .din_i(din_i), .din_q(din_q), .out_valid(out_valid), .out_ready(out_ready),
    .dout_i(dout_i), .dout_q(dout_q), .out_exp(out_exp), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [XW-1:0] di;
    logic [XW-1:0] dq;
    logic [EW-1:0] e;
    logic          last;
  } exp_t;

  exp_t          sb[$];
  logic [IW-1:0] blk_i [BB];
  logic [IW-1:0] blk_q [BB];
  int            nbeat  = 0;
  int            stored = 0;
  int            n_pass = 0, n_fail = 0, n_total = 0;
  logic [XW-1:0] rep255;

`ifdef CBFP_ROUND_EN
  localparam logic [OW-1:0] T2_LANE0 = 9'd146;
`else
  localparam logic [OW-1:0] T2_LANE0 = 9'd145;
`endif

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Largest k such that the top k+1 bits of x all agree.
  function automatic int m_rsc(input logic signed [DW-1:0] x);
    logic signed [DW-1:0] t;
    for (int k = DW - 1; k >= 0; k--) begin
      t = x >>> (DW - 1 - k);
      if (t == 0 || t == -1) return (k > SM) ? SM : k;
    end
    return 0;
  endfunction

  function automatic logic [OW-1:0] m_norm(input logic signed [DW-1:0] x, input int e);
    logic [DW-1:0] s;
    int            v;
    s = x << e;
    v = $signed(s[DW-1 -: OW]);
`ifdef CBFP_ROUND_EN
    v = v + int'(s[DW-OW-1]);
    if (v > (1 << (OW - 1)) - 1) v = (1 << (OW - 1)) - 1;
`endif
    return OW'(v);
  endfunction

  task automatic model_block();
    int   mn;
    exp_t ex;
    mn = SM;
    for (int b = 0; b < BB; b++)
      for (int l = 0; l < NL; l++) begin
        if (m_rsc(blk_i[b][l*DW +: DW]) < mn) mn = m_rsc(blk_i[b][l*DW +: DW]);
        if (m_rsc(blk_q[b][l*DW +: DW]) < mn) mn = m_rsc(blk_q[b][l*DW +: DW]);
      end
    for (int b = 0; b < BB; b++) begin
      for (int l = 0; l < NL; l++) begin
        ex.di[l*OW +: OW] = m_norm(blk_i[b][l*DW +: DW], mn);
        ex.dq[l*OW +: OW] = m_norm(blk_q[b][l*DW +: DW], mn);
      end
      ex.e    = EW'(mn);
      ex.last = (b == BB - 1);
      sb.push_back(ex);
    end
  endtask

  // Monitor: sample at negedge, before the posedge that commits the handshakes.
  always @(negedge clk) begin
    exp_t ex;
    if (!rstn || clr) begin
      sb.delete();
      nbeat  = 0;
      stored = 0;
    end else begin
      check("out_valid", out_valid, sb.size() != 0);
      check("in_ready", in_ready, stored < DEPTH);
      if (!out_valid) check("idle_zero", {dout_i, dout_q, out_exp, out_last}, '0);
      if (out_valid && out_ready && sb.size() != 0) begin
        ex = sb.pop_front();
        check("dout_i", dout_i, ex.di);
        check("dout_q", dout_q, ex.dq);
        check("out_exp", out_exp, ex.e);
        check("out_last", out_last, ex.last);
        stored--;
      end
      if (in_valid && in_ready) begin
        blk_i[nbeat] = din_i;
        blk_q[nbeat] = din_q;
        nbeat++;
        stored++;
        if (nbeat == BB) begin
          model_block();
          nbeat = 0;
        end
      end
    end
  end

  task automatic put_beat(input logic [IW-1:0] bi, input logic [IW-1:0] bq);
    int waited;
    waited   = 0;
    din_i    = bi;
    din_q    = bq;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 300) check("wr_timeout", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic put_const(input logic [DW-1:0] v, input int n);
    for (int i = 0; i < n; i++) put_beat({NL{v}}, {NL{v}});
  endtask

  function automatic logic [IW-1:0] rnd_beat(input int k);
    logic [IW-1:0]        v;
    logic signed [DW-1:0] s;
    for (int l = 0; l < NL; l++) begin
      s = DW'($urandom);
      s = s >>> $urandom_range(15, k);
      v[l*DW +: DW] = s;
    end
    return v;
  endfunction

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0 && !out_valid) break;
    end
    check("drain_empty", sb.size(), 0);
    out_ready = 1'b0;
  endtask

  initial begin
    bit wdone;
    rep255 = {NL{9'd255}};
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_outputs", {dout_i, dout_q, out_exp, out_last}, '0);
    rstn = 1'b1;

    // All 0x00FF: partial block hidden, then readable one cycle after the last beat.
    put_const(16'h00FF, 3);
    @(negedge clk);
    check("partial_hidden", out_valid, 1'b0);
    @(posedge clk);
    #1;
    put_const(16'h00FF, 1);
    check("t1_latency", out_valid, 1'b1);
    check("t1_exp", out_exp, 4'd7);
    check("t1_dout", dout_i, rep255);
    check("t1_first_not_last", out_last, 1'b0);
    drain();

    put_beat(IW'(16'h1234), '0);
    put_const(16'h0000, 3);
    check("t2_exp", out_exp, 4'd2);
    check("t2_lane0", dout_i[OW-1:0], T2_LANE0);
    drain();

    put_const(16'h7FFF, 4);
    check("t3_exp_max", out_exp, 4'd0);
    check("t3_dout_sat", dout_i, rep255);
    drain();
    put_const(16'h0000, 4);
    check("t3_exp_zero", out_exp, 4'd15);
    drain();
    put_const(16'hFFFF, 4);
    check("t3_exp_neg1", out_exp, 4'd15);
    drain();

    // Fill all 16 beats, then read one beat while a write is offered.
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) put_beat(rnd_beat(i % 8), rnd_beat(3));
    check("full_in_ready", in_ready, 1'b0);
    din_i     = rnd_beat(0);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("after_read_in_ready", in_ready, 1'b1);
    drain();

    // clr after two beats: the partial block and its running min are dropped.
    put_const(16'h4000, 2);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    check("clr_out_valid", out_valid, 1'b0);
    put_const(16'h0100, 4);
    check("clr_fresh_exp", out_exp, 4'd6);
    drain();

    put_const(16'h4000, 2);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    check("rst_mid_out_valid", out_valid, 1'b0);
    put_const(16'h0100, 4);
    check("rst_fresh_exp", out_exp, 4'd6);
    drain();

    // Random stream of 100 blocks with random valid/ready.
    wdone = 1'b0;
    fork
      begin
        for (int b = 0; b < 100; b++) begin
          int k;
          k = $urandom_range(0, 12);
          for (int j = 0; j < BB; j++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            put_beat(rnd_beat(k), rnd_beat(k));
          end
        end
        wdone = 1'b1;
      end
      begin
        while (!wdone) begin
          out_ready = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
      end
    join
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
